// File: rtl/round_timer_ctrl_if.sv
// Host command / status bundle between the timer PIO and the round countdown.
// The master drives commands; the slave (timer) drives status back.
interface round_timer_ctrl_if;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [6:0] cmd_value;
    logic [6:0] time_num;
    logic       running;
    logic       paused;
    logic       expired;
    logic       expire_pulse;
    logic       second_tick;
    logic       warn;
    logic       cmd_ack;

    modport master (
        output cmd_valid, cmd_op, cmd_value,
        input  time_num, running, paused, expired, expire_pulse, second_tick, warn, cmd_ack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_value,
        output time_num, running, paused, expired, expire_pulse, second_tick, warn, cmd_ack
    );
endinterface

// File: rtl/round_timer_ctrl.sv
// Commanded round countdown: LOAD/START/PAUSE/CLEAR on cmd_valid rising edge, one decrement per CLK_HZ cycles.
// All outputs registered, one-cycle command latency; no backpressure, a command is acknowledged the cycle after its edge.
module round_timer_ctrl #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int MAX_TIME = 99,
    parameter int WARN_AT  = 5
) (
    input  logic               clk,
    input  logic               reset,
    round_timer_ctrl_if.slave  tif
);
    localparam int             PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [6:0]     MAX_T      = 7'(MAX_TIME);
    localparam logic [6:0]     WARN_T     = 7'(WARN_AT);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_START = 2'b01, OP_PAUSE = 2'b10, OP_CLEAR = 2'b11} op_t;

    state_t          state_q, state_nxt;
    logic [6:0]      time_q, time_nxt;
    logic [PW-1:0]   presc_q, presc_nxt;
    logic            cmd_q;
    logic            ack_q, ack_nxt;
    logic            tick_q, tick_nxt;
    logic            xp_q, xp_nxt;
    logic            warn_q, warn_nxt;

    logic            cmd_edge;
    logic [6:0]      load_val;
    logic            presc_wrap;
    logic [PW-1:0]   presc_step;

    assign cmd_edge   = tif.cmd_valid & ~cmd_q;
    assign load_val   = (tif.cmd_value > MAX_T) ? MAX_T : tif.cmd_value;
    assign presc_wrap = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign presc_step = presc_wrap ? '0 : presc_q + PW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            presc_q <= '0;
            cmd_q   <= 1'b0;
            ack_q   <= 1'b0;
            tick_q  <= 1'b0;
            xp_q    <= 1'b0;
            warn_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            time_q  <= time_nxt;
            presc_q <= presc_nxt;
            cmd_q   <= tif.cmd_valid;
            ack_q   <= ack_nxt;
            tick_q  <= tick_nxt;
            xp_q    <= xp_nxt;
            warn_q  <= warn_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        time_nxt  = time_q;
        presc_nxt = presc_q;
        ack_nxt   = 1'b0;
        tick_nxt  = 1'b0;
        xp_nxt    = 1'b0;

        if (cmd_edge) begin
            // A command always beats a same-cycle tick; the tick's decrement is lost.
            ack_nxt = 1'b1;
            case (op_t'(tif.cmd_op))
                OP_LOAD: begin
                    time_nxt  = load_val;
                    presc_nxt = '0;
                    if (state_q == ST_DONE) begin
                        state_nxt = ST_IDLE;
                    end else if (state_q == ST_RUN && load_val == 7'd0) begin
                        state_nxt = ST_DONE;
                        xp_nxt    = 1'b1;
                    end
                end
                OP_START: begin
                    if (state_q == ST_IDLE || state_q == ST_PAUSE) begin
                        if (time_q == 7'd0) begin
                            state_nxt = ST_DONE;
                            xp_nxt    = 1'b1;
                        end else begin
                            state_nxt = ST_RUN;
                        end
                    end else if (state_q == ST_RUN) begin
                        presc_nxt = presc_step;
                    end
                end
                OP_PAUSE: begin
                    if (state_q == ST_RUN) begin
                        state_nxt = ST_PAUSE;
                        presc_nxt = presc_wrap ? '0 : presc_q;
                    end
                end
                OP_CLEAR: begin
                    state_nxt = ST_IDLE;
                    time_nxt  = '0;
                    presc_nxt = '0;
                end
                default: ;
            endcase
        end else if (state_q == ST_RUN) begin
            presc_nxt = presc_step;
            if (presc_wrap) begin
                tick_nxt = 1'b1;
                time_nxt = (time_q != 7'd0) ? time_q - 7'd1 : 7'd0;
                if (time_q <= 7'd1) begin
                    state_nxt = ST_DONE;
                    xp_nxt    = 1'b1;
                end
            end
        end

        warn_nxt = (state_nxt == ST_RUN) && (time_nxt <= WARN_T) && (time_nxt != 7'd0);
    end

    assign tif.time_num     = time_q;
    assign tif.running      = (state_q == ST_RUN);
    assign tif.paused       = (state_q == ST_PAUSE);
    assign tif.expired      = (state_q == ST_DONE);
    assign tif.expire_pulse = xp_q;
    assign tif.second_tick  = tick_q;
    assign tif.warn         = warn_q;
    assign tif.cmd_ack      = ack_q;
endmodule
